// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clock/reset sequencer and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_rst_pkg;

  // Sequencer phases, from wizard reset through to normal operation or give-up.
  typedef enum logic [2:0] {
    ST_RESET_MMCM = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABILIZE  = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } seq_state_t;

  // Width of the saturating lock-loss counter.
  localparam int LOSS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The shared cycle counter only ever has to reach (largest interval - 1).
  // A width of at least one bit is kept so degenerate parameter sets still
  // elaborate.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = max3(a, b, c);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clk_rst_sequencer_sync.sv
// Two-flop synchronizer for a single level signal; async reset to 0.
// Latency: input sampled at edge e is visible on q after edge e+1.
// Backpressure: none; a level signal with no handshake.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop absorbs metastability; second flop presents a clean level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_sequencer.sv
// Clocking-wizard bring-up: reset pulse, lock wait with timeout/retry, stability hold, run.
// Latency: lock seen 2 edges after sampling; release LOCK_STABLE_CYCLES edges after that.
// Backpressure: none; i_retry is a one-cycle request honoured only when in FAIL.
module clk_rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                             i_clk,
  input  logic                             reset,
  input  logic                             i_locked,
  input  logic                             i_retry,
  output logic                             o_mmcm_reset,
  output logic                             o_sys_reset,
  output logic                             o_ready,
  output logic                             o_error,
  output logic                             o_lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0] o_retry_count,
  output logic [LOSS_CNT_W-1:0]            o_loss_count
);

  localparam int CNT_W = cnt_width(RESET_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int RC_W  = $clog2(MAX_RETRIES + 1);

  // Terminal counts: the counter starts at 0 on state entry, so the edge that
  // completes an N-cycle interval is the one that sees cnt == N-1.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RETRIES);
  localparam logic [RC_W-1:0] RC_ONE = RC_W'(1);

  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_SAT = {LOSS_CNT_W{1'b1}};

  seq_state_t              state;
  seq_state_t              state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [RC_W-1:0]         retry_inc;
  logic [RC_W-1:0]         retry_nxt;
  logic [LOSS_CNT_W-1:0]   loss_nxt;
  logic                    lost_nxt;
  logic                    lk;

  // i_locked comes from the wizard's own clock domain; only lk is trusted.
  sync_2ff u_lock_sync (
    .clk (i_clk),
    .rst (reset),
    .d   (i_locked),
    .q   (lk)
  );

  assign retry_inc = o_retry_count + RC_ONE;

  // State and shared interval counter.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state <= ST_RESET_MMCM;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, retry/loss bookkeeping and counter update.
  always_comb begin
    state_nxt = state;
    retry_nxt = o_retry_count;
    loss_nxt  = o_loss_count;
    lost_nxt  = 1'b0;
    cnt_nxt   = cnt + CNT_ONE;

    case (state)
      ST_RESET_MMCM: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        // A lock seen on the timeout edge still wins over the retry.
        if (lk) begin
          state_nxt = ST_STABILIZE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_nxt = retry_inc;
          state_nxt = (retry_inc == RC_MAX) ? ST_FAIL : ST_RESET_MMCM;
        end
      end

      ST_STABILIZE: begin
        // A glitch restarts the lock wait without charging a retry.
        if (!lk) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
          retry_nxt = '0;
        end
      end

      ST_RUN: begin
        if (!lk) begin
          lost_nxt  = 1'b1;
          state_nxt = ST_RESET_MMCM;
          if (o_loss_count != LOSS_SAT) begin
            loss_nxt = o_loss_count + LOSS_ONE;
          end
        end
      end

      ST_FAIL: begin
        if (i_retry) begin
          state_nxt = ST_RESET_MMCM;
          retry_nxt = '0;
        end
      end

      default: begin
        state_nxt = ST_RESET_MMCM;
        retry_nxt = '0;
      end
    endcase

    // Every phase times itself from zero; RUN and FAIL have no interval, so
    // the counter is parked there rather than left free-running.
    if ((state_nxt != state) || (state_nxt == ST_RUN) || (state_nxt == ST_FAIL)) begin
      cnt_nxt = '0;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      o_mmcm_reset  <= 1'b1;
      o_sys_reset   <= 1'b1;
      o_ready       <= 1'b0;
      o_error       <= 1'b0;
      o_lock_lost   <= 1'b0;
      o_retry_count <= '0;
      o_loss_count  <= '0;
    end else begin
      o_mmcm_reset  <= (state_nxt == ST_RESET_MMCM) || (state_nxt == ST_FAIL);
      o_sys_reset   <= (state_nxt != ST_RUN);
      o_ready       <= (state_nxt == ST_RUN);
      o_error       <= (state_nxt == ST_FAIL);
      o_lock_lost   <= lost_nxt;
      o_retry_count <= retry_nxt;
      o_loss_count  <= loss_nxt;
    end
  end

endmodule
